adder_arbiter: RTL
==================

// Module: adder_arbiter
// PURPOSE
//  Shares one 4-input, two-stage pipelined signed adder tree between two requesters (A, B).
//  Each cycle it grants at most one requester by round-robin and steers that requester's four words into the adder.
//  It tags every issue and returns each sum with the ID of its requester, one issue per cycle at full throughput.
//  Sits between the requesting datapaths and the adder tree; the adder has no handshake and no stall.
// PARAMETERS
//  WIDTH  25  signed word/result width; must equal the adder width
//  LAT    2   adder latency in CLK edges, input sample to RES valid; >=1
//  CNT_W  16  width of the per-requester grant counters
// PORTS
//  CLK           in   1          clock, all logic on posedge
//  RST           in   1          synchronous reset, active-high
//  A_VALID       in   1          requester A has four words to sum
//  A_READY       out  1          A granted this cycle (handshake when A_VALID & A_READY)
//  A_DATA        in   4*WIDTH    A words; word k = A_DATA[k*WIDTH +: WIDTH], signed
//  B_VALID       in   1          requester B has four words to sum
//  B_READY       out  1          B granted this cycle
//  B_DATA        in   4*WIDTH    B words, same packing
//  ADD_WORD_0..3 out  WIDTH      operands to adder tree WORD_0..WORD_3 (combinational mux)
//  ADD_RES       in   WIDTH      adder tree RES
//  RES_VALID     out  1          RES_DATA/RES_ID valid this cycle
//  RES_DATA      out  WIDTH      signed sum (= ADD_RES)
//  RES_ID        out  1          0 = requester A, 1 = requester B
//  GRANT_CNT_A   out  CNT_W      saturating count of A grants since reset
//  GRANT_CNT_B   out  CNT_W      saturating count of B grants since reset
// BEHAVIOUR
//  - Reset (RST=1 at a posedge):
//    - Priority pointer goes to A.
//    - Tag pipe is cleared: all valid bits 0.
//    - GRANT_CNT_A and GRANT_CNT_B go to 0.
//    - RES_VALID is 0.
//  - While RST=1: A_READY=B_READY=0 and ADD_WORD_* = 0, regardless of A_VALID/B_VALID.
//  - Arbitration is combinational:
//    - A_READY = A_VALID & (prio==A | !B_VALID).
//    - B_READY = B_VALID & (prio==B | !A_VALID).
//    - At most one READY is high in any cycle.
//  - Priority pointer: after a grant it moves to the other requester; with no grant it holds.
//    - Both valid continuously -> grants alternate A,B,A,B...
//    - A single valid requester is granted every cycle.
//  - ADD_WORD_k = granted requester's word k; 0 when there is no grant.
//    - READY may depend on VALID.
//    - DATA need only be stable while VALID is high.
//  - Tag pipe: LAT-deep shift register of {valid, id}, shifting every posedge.
//    - Stage 0 loads {grant, granted id}.
//    - RES_VALID / RES_ID = last stage.
//    - RES_DATA = ADD_RES passthrough.
//  - Latency: handshake in cycle t -> RES_VALID=1 with the matching sum in cycle t+LAT.
//    - Results return in issue order; back-to-back issues give back-to-back results.
//  - Arithmetic is done by the adder, modulo 2^WIDTH two's complement; the arbiter does not change data or width.
//  - No result backpressure: consumers must accept RES whenever RES_VALID=1.
//  - Grant counters: +1 on each grant of their requester, saturating at 2^CNT_W-1 (no wrap).
//  - Reset mid-flight:
//    - In-flight tags are discarded, so RES_VALID stays 0 for LAT cycles after reset even though ADD_RES still carries old sums.
//    - After reset, priority is back at A.
// TESTING (bench connects ADD_* to the team's 4-input two-stage adder tree, LAT=2)
//  1. RST=1 for 3 cycles with A_VALID=B_VALID=1 -> READYs 0, ADD_WORD_*=0, RES_VALID 0, counters 0.
//  2. A only, words 1,2,3,4 for one cycle (t=0) -> A_READY=1 and ADD_WORD=1,2,3,4 at t=0; at t=2 RES_VALID=1, RES_DATA=10, RES_ID=0; RES_VALID=0 at t=3.
//  3. Both valid for 4 cycles, A words sum 10, B words 5,6,7,8 (sum 26) -> grants A,B,A,B; results at t=2..5 are (0,10),(1,26),(0,10),(1,26).
//  4. Wrap: A words all 16777215 -> RES_DATA = -4 (4*(2^24-1) mod 2^25, signed).
//  5. Grant A at t=0, RST=1 at t=1, B_VALID=1 from t=2 -> no RES_VALID at t=2 or t=3; first post-reset grant follows the A-priority rule; B's result appears 2 cycles after its grant.
//  6. CNT_W=4, A_VALID held for 20 cycles -> GRANT_CNT_A=15 and held; GRANT_CNT_B=0.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin front end that shares one pipelined 4-input signed adder tree between
// two requesters and tags every issue so each sum returns with its requester ID.
module adder_arbiter #(
  parameter int WIDTH = 25,
  parameter int LAT   = 2,
  parameter int CNT_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               A_VALID,
  output logic               A_READY,
  input  logic [4*WIDTH-1:0] A_DATA,
  input  logic               B_VALID,
  output logic               B_READY,
  input  logic [4*WIDTH-1:0] B_DATA,
  output logic [WIDTH-1:0]   ADD_WORD_0,
  output logic [WIDTH-1:0]   ADD_WORD_1,
  output logic [WIDTH-1:0]   ADD_WORD_2,
  output logic [WIDTH-1:0]   ADD_WORD_3,
  input  logic [WIDTH-1:0]   ADD_RES,
  output logic               RES_VALID,
  output logic [WIDTH-1:0]   RES_DATA,
  output logic               RES_ID,
  output logic [CNT_W-1:0]   GRANT_CNT_A,
  output logic [CNT_W-1:0]   GRANT_CNT_B
);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  prio_t              prio;
  prio_t              prio_nxt;
  logic               a_grant;
  logic               b_grant;
  logic               grant;
  logic [4*WIDTH-1:0] sel_data;
  logic [LAT-1:0]     tag_valid;
  logic [LAT-1:0]     tag_id;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) prio <= PRIO_A;
    else     prio <= prio_nxt;
  end

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    a_grant  = 1'b0;
    b_grant  = 1'b0;
    prio_nxt = prio;
    if (!RST) begin
      a_grant = A_VALID & ((prio == PRIO_A) | ~B_VALID);
      b_grant = B_VALID & ((prio == PRIO_B) | ~A_VALID);
    end
    if (a_grant)      prio_nxt = PRIO_B;
    else if (b_grant) prio_nxt = PRIO_A;
  end

  assign grant   = a_grant | b_grant;
  assign A_READY = a_grant;
  assign B_READY = b_grant;

  always_comb begin
    sel_data = '0;
    if (a_grant)      sel_data = A_DATA;
    else if (b_grant) sel_data = B_DATA;
  end

  assign ADD_WORD_0 = sel_data[0*WIDTH +: WIDTH];
  assign ADD_WORD_1 = sel_data[1*WIDTH +: WIDTH];
  assign ADD_WORD_2 = sel_data[2*WIDTH +: WIDTH];
  assign ADD_WORD_3 = sel_data[3*WIDTH +: WIDTH];

  // Tag pipe runs in lockstep with the adder; reset drops in-flight tags so stale sums are ignored.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tag_valid <= '0;
    end else begin
      tag_valid[0] <= grant;
      for (int k = 1; k < LAT; k++) tag_valid[k] <= tag_valid[k-1];
    end
  end

  // NOTE: the id bits are only meaningful alongside a valid bit, so they carry no reset.
  always_ff @(posedge CLK) begin
    tag_id[0] <= b_grant;
    for (int k = 1; k < LAT; k++) tag_id[k] <= tag_id[k-1];
  end

  assign RES_VALID = tag_valid[LAT-1];
  assign RES_ID    = tag_id[LAT-1];
  assign RES_DATA  = ADD_RES;

  // Grant counters stop at all-ones instead of wrapping.
  always_ff @(posedge CLK) begin
    if (RST)                          GRANT_CNT_A <= '0;
    else if (a_grant && ~&GRANT_CNT_A) GRANT_CNT_A <= GRANT_CNT_A + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST)                          GRANT_CNT_B <= '0;
    else if (b_grant && ~&GRANT_CNT_B) GRANT_CNT_B <= GRANT_CNT_B + 1'b1;
  end

endmodule
